// File: rtl/conv_core_pkg.sv
// +----------------------------------------------------------------------------+
// | conv_core_pkg                                                              |
// | Shared state encoding and geometry helpers for the convolutional core.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package conv_core_pkg;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_IDLE   = 2'd0;
  localparam sched_state_t ST_STREAM = 2'd1;
  localparam sched_state_t ST_DRAIN  = 2'd2;
  localparam sched_state_t ST_HOLD   = 2'd3;

  function automatic int npix(input int frame_width);
    return frame_width * frame_width;
  endfunction

  function automatic int oc_phases(input int out_channels, input int row_size);
    return out_channels / row_size;
  endfunction

  // Counter width able to hold 0..n-1 plus one guard bit.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_core_sched_valid_delay_line.sv
// +----------------------------------------------------------------------------+
// | valid_delay_line                                                           |
// | Fixed-depth shift register delaying a single valid bit by DEPTH cycles.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module valid_delay_line #(
  parameter int DEPTH = 28
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] r_sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sr <= '0;
        else        r_sr <= din;
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sr <= '0;
        else        r_sr <= {r_sr[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = r_sr[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/conv_core_sched.sv
// +----------------------------------------------------------------------------+
// | conv_core_sched                                                            |
// | Window sweep / time-step / output-channel-phase sequencer for the core.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module conv_core_sched
  import conv_core_pkg::*;
#(
  parameter int TIME_STEPS        = 3,
  parameter int OUT_CHANNELS      = 16,
  parameter int PE_ARRAY_ROW_SIZE = 2,
  parameter int FRAME_WIDTH       = 6,
  parameter int IN_CHANNELS       = 3,
  parameter int KERNEL_SIZE       = 3,
  parameter int THRESH_LAT        = IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE+1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    pre_syn_RAM_loaded,
  input  logic                                    spk_ack,
  output logic [$clog2(FRAME_WIDTH*FRAME_WIDTH):0] pix_iter,
  output logic                                    pix_valid,
  output logic                                    en_thresh,
  output logic                                    transit,
  output logic                                    new_oc,
  output logic [$clog2(TIME_STEPS):0]             time_step,
  output logic [$clog2(OUT_CHANNELS):0]           oc_phase,
  output logic                                    new_spk_train_ready,
  output logic                                    post_syn_RAM_loaded,
  output logic                                    busy
);

  localparam int NPIX      = npix(FRAME_WIDTH);
  localparam int OC_PHASES = oc_phases(OUT_CHANNELS, PE_ARRAY_ROW_SIZE);
  localparam int PIX_W     = $clog2(FRAME_WIDTH*FRAME_WIDTH) + 1;
  localparam int TS_W      = $clog2(TIME_STEPS) + 1;
  localparam int OC_W      = $clog2(OUT_CHANNELS) + 1;
  localparam int DR_W      = cnt_w(THRESH_LAT);

  localparam logic [PIX_W-1:0] c_pix_last   = PIX_W'(NPIX - 1);
  localparam logic [TS_W-1:0]  c_ts_last    = TS_W'(TIME_STEPS - 1);
  localparam logic [OC_W-1:0]  c_oc_last    = OC_W'(OC_PHASES - 1);
  localparam logic [DR_W-1:0]  c_drain_last = DR_W'(THRESH_LAT - 1);

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [PIX_W-1:0] r_pix_iter;
  logic [TS_W-1:0]  r_time_step;
  logic [OC_W-1:0]  r_oc_phase;
  logic [DR_W-1:0]  r_drain_cnt;
  logic             r_transit;
  logic             r_new_oc;
  logic             r_post_syn;
  logic             w_leave;
  logic             w_last_step;
  logic             w_last_phase;

  assign w_leave      = (r_state == ST_HOLD) && spk_ack;
  assign w_last_step  = (r_time_step == c_ts_last);
  assign w_last_phase = (r_oc_phase == c_oc_last);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (pre_syn_RAM_loaded)          w_state_nxt = ST_STREAM;
      ST_STREAM: if (r_pix_iter == c_pix_last)    w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (r_drain_cnt == c_drain_last) w_state_nxt = ST_HOLD;
      ST_HOLD:   if (spk_ack)
                   w_state_nxt = (w_last_step && w_last_phase) ? ST_IDLE : ST_STREAM;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // The window index stays on its last value through DRAIN/HOLD and only
  // rewinds when the spike train is acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pix_iter  <= '0;
      r_time_step <= '0;
      r_oc_phase  <= '0;
      r_drain_cnt <= '0;
      r_transit   <= 1'b0;
      r_new_oc    <= 1'b0;
      r_post_syn  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_transit  <= w_leave;
      r_new_oc   <= w_leave && w_last_step;
      r_post_syn <= w_leave && w_last_step && w_last_phase;

      if (r_state == ST_STREAM) begin
        r_drain_cnt <= '0;
        if (r_pix_iter != c_pix_last) r_pix_iter <= r_pix_iter + 1'b1;
      end

      if ((r_state == ST_DRAIN) && (r_drain_cnt != c_drain_last))
        r_drain_cnt <= r_drain_cnt + 1'b1;

      if (w_leave) begin
        r_pix_iter <= '0;
        if (w_last_step) begin
          r_time_step <= '0;
          r_oc_phase  <= w_last_phase ? '0 : r_oc_phase + 1'b1;
        end else begin
          r_time_step <= r_time_step + 1'b1;
        end
      end
    end
  end

  valid_delay_line #(
    .DEPTH (THRESH_LAT)
  ) u_en_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pix_valid),
    .dout  (en_thresh)
  );

  assign pix_iter            = r_pix_iter;
  assign pix_valid           = (r_state == ST_STREAM);
  assign transit             = r_transit;
  assign new_oc              = r_new_oc;
  assign time_step           = r_time_step;
  assign oc_phase            = r_oc_phase;
  assign new_spk_train_ready = (r_state == ST_HOLD);
  assign post_syn_RAM_loaded = r_post_syn;
  assign busy                = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_conv_core_sched.sv
// +----------------------------------------------------------------------------+
// | tb_conv_core_sched                                                         |
// | Scoreboard bench: stimulus queues expected issues/transits, monitor pops. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_conv_core_sched;

  localparam int TS   = 3;
  localparam int OCP  = 8;   // 16 channels / 2 per row
  localparam int NPIX = 36;
  localparam int LAT  = 28;  // 3*3*3+1

  typedef struct packed { logic [7:0] ts; logic [7:0] oc; logic [7:0] pix; } pix_t;
  typedef struct packed { logic new_oc; logic post; logic [7:0] ts; logic [7:0] oc; } evt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pre = 1'b0;
  logic ack = 1'b0;

  logic [6:0] pix_iter;
  logic       pix_valid, en_thresh, transit, new_oc, ready, post, busy;
  logic [2:0] time_step;
  logic [4:0] oc_phase;

  logic       pre_b = 1'b0;
  logic       ack_b = 1'b1;
  logic [6:0] pix_iter_b;
  logic       pix_valid_b, en_thresh_b, transit_b, new_oc_b, ready_b, post_b, busy_b;
  logic [0:0] time_step_b;
  logic [1:0] oc_phase_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_first = 0;
  int t_post = 0;
  int post_cnt = 0;
  int pv_cnt_b = 0;
  bit arm_first = 0;
  bit post_seen = 0;
  bit mon_en = 1;
  logic [LAT-1:0] hist = '0;

  pix_t exp_pix[$];
  evt_t exp_evt[$];

  always #5 clk = ~clk;

  conv_core_sched u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pre_syn_RAM_loaded  (pre),
    .spk_ack             (ack),
    .pix_iter            (pix_iter),
    .pix_valid           (pix_valid),
    .en_thresh           (en_thresh),
    .transit             (transit),
    .new_oc              (new_oc),
    .time_step           (time_step),
    .oc_phase            (oc_phase),
    .new_spk_train_ready (ready),
    .post_syn_RAM_loaded (post),
    .busy                (busy)
  );

  conv_core_sched #(
    .TIME_STEPS        (1),
    .OUT_CHANNELS      (2),
    .PE_ARRAY_ROW_SIZE (2)
  ) u_dut_b (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pre_syn_RAM_loaded  (pre_b),
    .spk_ack             (ack_b),
    .pix_iter            (pix_iter_b),
    .pix_valid           (pix_valid_b),
    .en_thresh           (en_thresh_b),
    .transit             (transit_b),
    .new_oc              (new_oc_b),
    .time_step           (time_step_b),
    .oc_phase            (oc_phase_b),
    .new_spk_train_ready (ready_b),
    .post_syn_RAM_loaded (post_b),
    .busy                (busy_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops expectations whenever the DUT issues a window or a transit.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (pix_valid) begin
        if (exp_pix.size() == 0) fail_now("pix_unexpected");
        else begin
          pix_t p;
          p = exp_pix.pop_front();
          chk("pix_iter", pix_iter, p.pix);
          chk("pix_ts", time_step, p.ts);
          chk("pix_oc", oc_phase, p.oc);
        end
      end
      if (transit) begin
        if (exp_evt.size() == 0) fail_now("transit_unexpected");
        else begin
          evt_t e;
          e = exp_evt.pop_front();
          chk("evt_new_oc", new_oc, e.new_oc);
          chk("evt_post", post, e.post);
          chk("evt_ts", time_step, e.ts);
          chk("evt_oc", oc_phase, e.oc);
          chk("evt_ready_low", ready, 0);
        end
      end else begin
        chk("new_oc_alone", new_oc, 0);
        chk("post_alone", post, 0);
      end
      chk("en_thresh", en_thresh, hist[LAT-1]);
    end
    if (!rst_n) hist = '0;
    else        hist = {hist[LAT-2:0], pix_valid};
    if (post) begin
      post_cnt++;
      post_seen = 1;
      t_post = cyc;
    end
    if (pix_valid && arm_first) begin
      t_first = cyc;
      arm_first = 0;
    end
    if (pix_valid_b) pv_cnt_b++;
  end

  task automatic push_layer();
    pix_t p;
    evt_t e;
    for (int oc = 0; oc < OCP; oc++) begin
      for (int ts = 0; ts < TS; ts++) begin
        for (int px = 0; px < NPIX; px++) begin
          p.ts = 8'(ts); p.oc = 8'(oc); p.pix = 8'(px);
          exp_pix.push_back(p);
        end
        e.new_oc = (ts == TS-1);
        e.post   = (ts == TS-1) && (oc == OCP-1);
        e.ts     = (ts == TS-1) ? 8'd0 : 8'(ts+1);
        e.oc     = (ts == TS-1) ? ((oc == OCP-1) ? 8'd0 : 8'(oc+1)) : 8'(oc);
        exp_evt.push_back(e);
      end
    end
  endtask

  task automatic start_layer();
    arm_first = 1;
    post_seen = 0;
    @(negedge clk); pre = 1'b1;
    @(negedge clk); pre = 1'b0;
    chk("start_pix_valid", pix_valid, 1);
    chk("start_pix_iter", pix_iter, 0);
  endtask

  task automatic wait_post(input int lim, input string nm);
    int n = 0;
    while (!post_seen && n < lim) begin @(negedge clk); n++; end
    chk(nm, post_seen, 1);
    @(negedge clk);
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_pixq"}, exp_pix.size(), 0);
    chk({nm, "_evtq"}, exp_evt.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [6:0] pix_hold;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_en_thresh", en_thresh, 0);
    chk("rst_ts_oc", {time_step, oc_phase}, 0);
    chk("rst_b_busy", busy_b, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full layer, ack tied high: 24 steps of 65 cycles
    ack = 1'b1;
    push_layer();
    start_layer();
    wait_post(3000, "layer1_post");
    chk("layer1_latency", t_post - t_first, 24*65);
    chk("layer1_post_cnt", post_cnt, 1);

    // stall in HOLD plus spurious ack / pre_syn
    ack = 1'b0;
    push_layer();
    start_layer();
    repeat (4) @(negedge clk);
    ack = 1'b1;
    repeat (3) @(negedge clk);
    ack = 1'b0;
    n = 0;
    while (pix_valid && n < 100) begin @(negedge clk); n++; end
    chk("stream_len_bound", pix_valid, 0);
    pre = 1'b1;
    repeat (3) @(negedge clk);
    pre = 1'b0;
    n = 0;
    while (!ready && n < 100) begin @(negedge clk); n++; end
    chk("hold_reached", ready, 1);
    pix_hold = pix_iter;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("stall_ready", ready, 1);
      chk("stall_transit", transit, 0);
      chk("stall_pix_valid", pix_valid, 0);
      chk("stall_ts_oc", {time_step, oc_phase}, 0);
      chk("stall_pix_iter", pix_iter, pix_hold);
    end
    ack = 1'b1;
    wait_post(3000, "layer2_post");
    chk("layer2_post_cnt", post_cnt, 2);

    // reset mid-STREAM at oc_phase 3
    push_layer();
    start_layer();
    n = 0;
    while (!(pix_valid && oc_phase == 5'd3 && pix_iter == 7'd10) && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("reach_oc3", oc_phase, 3);
    @(posedge clk);
    #2;
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("arst_pix", {pix_valid, pix_iter}, 0);
    chk("arst_ctl", {en_thresh, transit, new_oc, ready, post, busy}, 0);
    chk("arst_ts_oc", {time_step, oc_phase}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_pix.delete();
    exp_evt.delete();
    repeat (20) @(negedge clk);
    chk("arst_no_post", post_cnt, 2);
    chk("arst_stay_idle", busy, 0);
    mon_en = 1;
    push_layer();
    start_layer();
    wait_post(3000, "layer3_post");
    chk("layer3_post_cnt", post_cnt, 3);

    // single step, single phase variant
    pv_cnt_b = 0;
    @(negedge clk); pre_b = 1'b1;
    @(negedge clk); pre_b = 1'b0;
    chk("b_start", pix_valid_b, 1);
    n = 0;
    while (!transit_b && n < 200) begin @(negedge clk); n++; end
    chk("b_transit", transit_b, 1);
    chk("b_new_oc", new_oc_b, 1);
    chk("b_post", post_b, 1);
    chk("b_pix_count", pv_cnt_b, 36);
    chk("b_ts_oc", {time_step_b, oc_phase_b}, 0);
    chk("b_idle", busy_b, 0);
    @(negedge clk);
    chk("b_transit_pulse", {transit_b, new_oc_b, post_b}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
